// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Program memory plus PC sequencer that holds each instruction on
//            `instr` for its class-dependent decode/execute/retire length.
//            Optional build macro FETCH_WRAP_EN: wrap from the last address
//            to 0 instead of halting.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    localparam int                 c_DEPTH     = 1 << PC_BITS;
    localparam logic [PC_BITS-1:0] c_PC_LAST   = {PC_BITS{1'b1}};
    localparam logic [PC_BITS-1:0] c_PC_ONE    = {{(PC_BITS-1){1'b0}}, 1'b1};
    localparam logic [1:0]         c_CLS_HALT  = 2'b00;
    localparam logic [1:0]         c_CLS_STD   = 2'b01;
    localparam logic [1:0]         c_CLS_LOAD  = 2'b10;
    localparam logic [1:0]         c_CLS_STORE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic [PC_BITS-1:0]     r_pc;
    logic [PC_BITS-1:0]     w_pc_nxt;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_nxt;

    logic [INSTR_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic [PC_BITS-1:0]     w_pc_inc;
    logic [PC_BITS-1:0]     w_fetch_addr;
    logic [INSTR_WIDTH-1:0] w_fetch_word;
    logic [1:0]             w_fetch_cls;
    logic [2:0]             w_fetch_len;
    logic                   w_mem_end;

    function automatic logic [2:0] f_hold_len(input logic [1:0] cls);
        case (cls)
            c_CLS_LOAD:            f_hold_len = 3'd4;
            c_CLS_STD, c_CLS_STORE: f_hold_len = 3'd3;
            default:               f_hold_len = 3'd0;
        endcase
    endfunction

    // IDLE always fetches address 0; RUN looks one word ahead of the PC.
    assign w_pc_inc     = r_pc + c_PC_ONE;
    assign w_fetch_addr = (r_state == S_IDLE) ? '0 : w_pc_inc;
    assign w_fetch_word = r_mem[w_fetch_addr];
    assign w_fetch_cls  = w_fetch_word[INSTR_WIDTH-1 -: 2];
    assign w_fetch_len  = f_hold_len(w_fetch_cls);

`ifdef FETCH_WRAP_EN
    assign w_mem_end = 1'b0;
`else
    assign w_mem_end = (r_pc == c_PC_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_pc    <= '0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt = '0;
                    if (w_fetch_cls == c_CLS_HALT) begin
                        w_state_nxt = S_HALT;
                        w_instr_nxt = '0;
                    end else begin
                        // Full length (not len-1): first word also covers the
                        // control unit's exit from its RESET state.
                        w_state_nxt = S_RUN;
                        w_instr_nxt = w_fetch_word;
                        w_cnt_nxt   = w_fetch_len;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (w_mem_end || (w_fetch_cls == c_CLS_HALT)) begin
                    w_state_nxt = S_HALT;
                    w_instr_nxt = '0;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_instr_nxt = w_fetch_word;
                    w_pc_nxt    = w_pc_inc;
                    w_cnt_nxt   = w_fetch_len - 3'd1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Program memory survives reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign instr  = r_instr;
    assign pc     = r_pc;
    assign busy   = (r_state == S_RUN);
    assign halted = (r_state == S_HALT);

endmodule
`default_nettype wire
